// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with level flags, overflow/underflow pulses and selectable FWFT read
module sync_fifo_param #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 2,
    parameter int FWFT       = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] DIN,
    input  logic              DIN_DV,
    output logic              FULL,
    output logic              AFULL,
    input  logic              RD_EN,
    output logic [DATA_W-1:0] DOUT,
    output logic              DOUT_DV,
    output logic              EMPTY,
    output logic              AEMPTY,
    output logic [ADDR_W:0]   COUNT,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W + 1)'(AFULL_LVL);
    localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W + 1)'(AEMPTY_LVL);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic full_q, full_d, empty_q, empty_d, afull_q, afull_d, aempty_q, aempty_d;
    logic dout_dv_q, dout_dv_d, ovf_q, ovf_d, udf_q, udf_d;
    logic wr_acc, rd_acc;
    always_comb begin
        wr_acc    = DIN_DV & ~full_q;
        rd_acc    = RD_EN & ~empty_q;
        wr_ptr_d  = wr_ptr_q + ADDR_W'(wr_acc);
        rd_ptr_d  = rd_ptr_q + ADDR_W'(rd_acc);
        count_d   = count_q + (ADDR_W + 1)'(wr_acc) - (ADDR_W + 1)'(rd_acc);
        full_d    = count_d == DEPTH_C;
        empty_d   = count_d == '0;
        afull_d   = count_d >= AFULL_C;
        aempty_d  = count_d <= AEMPTY_C;
        dout_d    = rd_acc ? mem_q[rd_ptr_q] : dout_q;
        dout_dv_d = rd_acc;
        ovf_d     = DIN_DV & full_q;
        udf_d     = RD_EN & empty_q;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            dout_q    <= '0;
            dout_dv_q <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            dout_q    <= dout_d;
            dout_dv_q <= dout_dv_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end
    // storage is deliberately left uninitialised on reset
    always_ff @(posedge CLK) begin
        if (wr_acc && !RST) mem_q[wr_ptr_q] <= DIN;
    end
    assign DOUT      = (FWFT != 0) ? mem_q[rd_ptr_q] : dout_q;
    assign DOUT_DV   = (FWFT != 0) ? ~empty_q : dout_dv_q;
    assign FULL      = full_q;
    assign EMPTY     = empty_q;
    assign AFULL     = afull_q;
    assign AEMPTY    = aempty_q;
    assign COUNT     = count_q;
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: standard and FWFT instances share stimulus, checked against a queue model
module tb_sync_fifo_param;
    logic clk = 1'b0, rst = 1'b0, din_dv = 1'b0, rd_en = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout0, dout1;
    logic [4:0] count0, count1;
    logic full0, afull0, dv0, empty0, aempty0, ovf0, udf0;
    logic full1, afull1, dv1, empty1, aempty1, ovf1, udf1;
    int n_cmp = 0, n_bad = 0;
    logic [7:0] q[$];
    logic [7:0] m_dout = '0;
    bit m_dv = 0, m_ovf = 0, m_udf = 0;
    typedef struct {
        bit r, dv, rd;
        logic [7:0] d;
        int cnt;
        bit emp, ful, ovf, udf;
    } vec_t;
    vec_t vt[7];

    sync_fifo_param #(.FWFT(0)) u0 (
        .CLK(clk), .RST(rst), .DIN(din), .DIN_DV(din_dv), .FULL(full0), .AFULL(afull0),
        .RD_EN(rd_en), .DOUT(dout0), .DOUT_DV(dv0), .EMPTY(empty0), .AEMPTY(aempty0),
        .COUNT(count0), .OVERFLOW(ovf0), .UNDERFLOW(udf0));
    sync_fifo_param #(.FWFT(1)) u1 (
        .CLK(clk), .RST(rst), .DIN(din), .DIN_DV(din_dv), .FULL(full1), .AFULL(afull1),
        .RD_EN(rd_en), .DOUT(dout1), .DOUT_DV(dv1), .EMPTY(empty1), .AEMPTY(aempty1),
        .COUNT(count1), .OVERFLOW(ovf1), .UNDERFLOW(udf1));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit dv, input logic [7:0] d, input bit rd);
        bit wacc, racc;
        int n;
        rst = r; din_dv = dv; din = d; rd_en = rd;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_dout = '0; m_dv = 0; m_ovf = 0; m_udf = 0;
        end else begin
            wacc = dv && q.size() < 16;
            racc = rd && q.size() > 0;
            m_dv = racc;
            if (racc) m_dout = q.pop_front();
            if (wacc) q.push_back(d);
            m_ovf = dv && !wacc;
            m_udf = rd && !racc;
        end
        #1;
        n = q.size();
        check("count", count0, n);
        check("count_fwft", count1, n);
        check("full", full0, n == 16);
        check("empty", empty0, n == 0);
        check("afull", afull0, n >= 12);
        check("aempty", aempty0, n <= 2);
        check("overflow", ovf0, m_ovf);
        check("underflow", udf0, m_udf);
        check("overflow_fwft", ovf1, m_ovf);
        check("underflow_fwft", udf1, m_udf);
        check("dout_dv", dv0, m_dv);
        check("dout", dout0, m_dout);
        check("dout_dv_fwft", dv1, n > 0);
        if (n > 0) check("dout_fwft", dout1, q[0]);
    endtask

    initial begin
        vt[0] = '{r:1, dv:0, rd:0, d:8'h00, cnt:0, emp:1, ful:0, ovf:0, udf:0};
        vt[1] = '{r:0, dv:0, rd:0, d:8'h00, cnt:0, emp:1, ful:0, ovf:0, udf:0};
        vt[2] = '{r:0, dv:0, rd:1, d:8'h00, cnt:0, emp:1, ful:0, ovf:0, udf:1};
        vt[3] = '{r:0, dv:0, rd:0, d:8'h00, cnt:0, emp:1, ful:0, ovf:0, udf:0};
        vt[4] = '{r:0, dv:1, rd:1, d:8'h77, cnt:1, emp:0, ful:0, ovf:0, udf:1};
        vt[5] = '{r:0, dv:0, rd:1, d:8'h00, cnt:0, emp:1, ful:0, ovf:0, udf:0};
        vt[6] = '{r:1, dv:0, rd:0, d:8'h00, cnt:0, emp:1, ful:0, ovf:0, udf:0};
        for (int i = 0; i < 7; i++) begin
            step(vt[i].r, vt[i].dv, vt[i].d, vt[i].rd);
            check($sformatf("vec%0d_count", i), count0, vt[i].cnt);
            check($sformatf("vec%0d_empty", i), empty0, vt[i].emp);
            check($sformatf("vec%0d_full", i), full0, vt[i].ful);
            check($sformatf("vec%0d_ovf", i), ovf0, vt[i].ovf);
            check($sformatf("vec%0d_udf", i), udf0, vt[i].udf);
        end
        check("reset_dv", dv0, 0);
        check("reset_aempty", aempty0, 1);
        // fill to full, then overflow, then simultaneous request when full
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 8'(i), 0);
            check("fill_afull", afull0, i >= 12);
        end
        check("fill_full", full0, 1);
        check("fill_count", count0, 16);
        step(0, 1, 8'hAA, 0);
        check("ovf_pulse", ovf0, 1);
        check("ovf_count", count0, 16);
        step(0, 1, 8'hBB, 1);
        check("full_both_count", count0, 15);
        check("full_both_ovf", ovf0, 1);
        check("full_both_dout", dout0, 8'h01);
        for (int i = 2; i <= 16; i++) begin
            step(0, 0, 0, 1);
            check("drain_dout", dout0, 8'(i));
            check("drain_dv", dv0, 1);
        end
        step(0, 0, 0, 0);
        check("drain_empty", empty0, 1);
        check("drain_dv_low", dv0, 0);
        check("drain_hold", dout0, 8'h10);
        // steady occupancy of 5 while streaming, pointers wrap several times
        for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom), 0);
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 8'($urandom), 1);
            check("stream_count", count0, 5);
        end
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 1, 8'h5A, 0);
        check("fwft_dout", dout1, 8'h5A);
        check("fwft_dv", dv1, 1);
        check("std_dv_idle", dv0, 0);
        step(0, 0, 0, 0);
        check("fwft_hold", dout1, 8'h5A);
        step(0, 0, 0, 1);
        check("fwft_pop_dv", dv1, 0);
        check("std_pop_dout", dout0, 8'h5A);
        // reset mid-stream discards contents
        for (int i = 0; i < 9; i++) step(0, 1, 8'(8'h40 + i), 0);
        step(1, 1, 8'h99, 0);
        check("rst_count", count0, 0);
        check("rst_empty", empty0, 1);
        check("rst_dv", dv0, 0);
        check("rst_dv_fwft", dv1, 0);
        step(0, 1, 8'h33, 0);
        check("post_rst_fwft", dout1, 8'h33);
        step(0, 0, 0, 1);
        check("post_rst_dout", dout0, 8'h33);
        check("post_rst_dv", dv0, 1);
        // random traffic alternating write-heavy and read-heavy phases
        for (int i = 0; i < 3000; i++) begin
            bit wh;
            wh = ((i / 150) % 2) == 0;
            step($urandom_range(0, 299) == 0,
                 wh ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 8'($urandom),
                 wh ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, the successor of our fixed 1-bit x16 FIFO. Provides configurable data width and depth. Adds full/empty, almost-full/almost-empty and occupancy outputs, plus overflow/underflow pulses. Read mode is selectable: standard (registered, 1-cycle latency) or first-word-fall-through. Used for rate buffering between same-clock pipeline stages.

Parameters:
DATA_W, 8, data word width in bits (>=1)
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words (ADDR_W>=1)
AFULL_LVL, 12, AFULL asserted when COUNT >= AFULL_LVL
AEMPTY_LVL, 2, AEMPTY asserted when COUNT <= AEMPTY_LVL; legal range 0 <= AEMPTY_LVL < AFULL_LVL <= DEPTH
FWFT, 0, 0 = standard read mode, 1 = first-word-fall-through

Ports:
CLK  in  1  clock, all logic on posedge
RST  in  1  synchronous reset, active-high
DIN  in  DATA_W  write data
DIN_DV  in  1  write request
FULL  out  1  COUNT == DEPTH
AFULL  out  1  almost full
RD_EN  in  1  read/pop request
DOUT  out  DATA_W  read data
DOUT_DV  out  1  DOUT valid
EMPTY  out  1  COUNT == 0
AEMPTY  out  1  almost empty
COUNT  out  ADDR_W+1  words stored, 0..DEPTH
OVERFLOW  out  1  1-cycle pulse: write rejected
UNDERFLOW  out  1  1-cycle pulse: read rejected

Behaviour:
- Clocking and reset: one clock CLK. Reset RST is synchronous, active-high, and has priority over DIN_DV and RD_EN in the same cycle.
- Reset values: write/read pointers 0, COUNT 0, EMPTY 1, AEMPTY 1, FULL 0, AFULL 0, DOUT 0, DOUT_DV 0, OVERFLOW 0, UNDERFLOW 0. Storage array is not cleared.
- Reset mid-operation discards all stored words. The first word written after reset is the first word read.
- Write accept: wr_acc = DIN_DV & ~FULL. On wr_acc, mem[wr_ptr] <= DIN and wr_ptr increments. If DIN_DV & FULL, nothing is written and OVERFLOW pulses high the next cycle.
- Read accept: rd_acc = RD_EN & ~EMPTY. If RD_EN & EMPTY, nothing is popped and UNDERFLOW pulses high the next cycle.
- Pointers: ADDR_W bits each, wrap modulo DEPTH with no special case.
- Full/empty decisions use registered flags only. There is no write-through-when-full and no read-bypass-when-empty.
- Simultaneous accepted write and read: COUNT unchanged; both pointers advance.
- When empty: write+read in the same cycle gives write accepted, read rejected, UNDERFLOW pulse.
- When full: write+read in the same cycle gives read accepted, write rejected, OVERFLOW pulse.
- COUNT update: COUNT <= COUNT + wr_acc - rd_acc.
- Flag timing: FULL, EMPTY, AFULL and AEMPTY are registered, computed from the next COUNT value. They change in the same cycle COUNT changes, i.e. the cycle after the accepting edge.
- Standard mode (FWFT=0): on rd_acc at edge n, DOUT <= mem[rd_ptr] and DOUT_DV = 1 in cycle n+1 only. DOUT holds its last value when DOUT_DV = 0. Read latency is 1 cycle.
- FWFT mode (FWFT=1): DOUT = mem[rd_ptr] (head word) and DOUT_DV = ~EMPTY. RD_EN while DOUT_DV = 1 pops the head; the next word or EMPTY is visible the following cycle.
- FWFT latency: a word written to an empty FIFO at edge n appears on DOUT with DOUT_DV = 1 in cycle n+1.
- Data integrity: words are read out in write order. There is no loss or duplication across pointer wrap.

Test Plan:
- Reset then idle -> EMPTY=1, AEMPTY=1, FULL=0, COUNT=0, DOUT_DV=0. RD_EN=1 for one cycle -> UNDERFLOW pulses once, COUNT stays 0.
- FWFT=0, write 0x01..0x10 (16 words, ADDR_W=4) -> FULL=1, COUNT=16, AFULL=1 from COUNT=12. 17th write 0xAA -> OVERFLOW pulse, COUNT=16. Read 16 -> DOUT 0x01..0x10 in order, each 1 cycle after RD_EN, then EMPTY=1.
- Simultaneous write/read at COUNT=5 for 40 cycles -> COUNT stays 5, pointers wrap twice, output sequence equals input sequence.
- Full FIFO with DIN_DV=1, RD_EN=1 in one cycle -> read accepted, write rejected, OVERFLOW=1, COUNT=15. Empty FIFO with both requests -> COUNT=1, UNDERFLOW=1.
- FWFT=1: write 0x5A to empty FIFO -> DOUT=0x5A, DOUT_DV=1 next cycle with no RD_EN. RD_EN=1 -> DOUT_DV=0 next cycle.
- Fill 9 words, assert RST mid-stream with DIN_DV=1 -> next cycle COUNT=0, EMPTY=1, DOUT_DV=0. Write 0x33 then read -> 0x33 returned.
